ofm_writeback: RTL and testbench

//  Receiving end of the PE-array output interface: captures the per-PE 8-bit activations when all PEs

---
 rtl/ofm_writeback.sv | 169 ++++++++++++++++
 tb/tb_ofm_writeback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback.sv
//==============================================================================
// Module      : ofm_writeback
// Description : Captures full PE-array output beats, packs channel bytes into
//               32-bit words and writes them to the OFM BRAM in HWC order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ofm_writeback #(
    parameter int NUM_PE   = 16,
    parameter int ADDR_W   = 20,
    parameter int OFM_W    = 56,
    parameter int OFM_H    = 56,
    parameter int NUM_TILE = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_PE-1:0]     valid,
    input  logic [NUM_PE*8-1:0]   ofm_in,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_ovf,
    output logic                  err_partial
);

    localparam int c_NPIX   = OFM_W * OFM_H;
    localparam int c_CH     = NUM_PE * NUM_TILE;
    localparam int c_NW     = NUM_PE / 4;
    localparam int c_PIX_W  = (c_NPIX > 1)   ? $clog2(c_NPIX)   : 1;
    localparam int c_TILE_W = (NUM_TILE > 1) ? $clog2(NUM_TILE) : 1;
    localparam int c_K_W    = (c_NW > 1)     ? $clog2(c_NW)     : 1;

    localparam logic [c_PIX_W-1:0]  c_PIX_LAST  = c_PIX_W'(c_NPIX - 1);
    localparam logic [c_TILE_W-1:0] c_TILE_LAST = c_TILE_W'(NUM_TILE - 1);
    localparam logic [c_K_W-1:0]    c_K_LAST    = c_K_W'(c_NW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_PIX_W-1:0]    r_pix;
    logic [c_TILE_W-1:0]   r_tile;
    logic [NUM_PE*8-1:0]   r_fifo_data [2];
    logic [ADDR_W-1:0]     r_fifo_addr [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic [c_K_W-1:0]      r_k;

    logic                  w_beat;
    logic                  w_partial;
    logic                  w_last_beat;
    logic                  w_emit;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_ovf;
    logic [ADDR_W-1:0]     w_base;
    logic [NUM_PE*8-1:0]   w_src_data;
    logic [ADDR_W-1:0]     w_src_addr;
    logic [31:0]           w_words [c_NW];

    assign w_beat      = (r_state == S_RUN) && (valid == '1);
    assign w_partial   = (r_state == S_RUN) && (valid != '0) && (valid != '1);
    assign w_last_beat = w_beat && (r_pix == c_PIX_LAST) && (r_tile == c_TILE_LAST);

    // With an empty FIFO the incoming beat bypasses straight to the output
    // register so its first word appears the cycle after capture.
    assign w_emit  = (r_count != 2'd0) || w_beat;
    assign w_pop   = w_emit && (r_k == c_K_LAST);
    assign w_push  = w_beat && ((r_count != 2'd2) || w_pop);
    assign w_ovf   = w_beat && !w_push;

    assign w_base     = ADDR_W'((32'(r_pix) * 32'(c_CH) + 32'(r_tile) * 32'(NUM_PE)) >> 2);
    assign w_src_data = (r_count == 2'd0) ? ofm_in : r_fifo_data[r_rd_ptr];
    assign w_src_addr = (r_count == 2'd0) ? w_base : r_fifo_addr[r_rd_ptr];

    // Word k carries channels 4k..4k+3, lowest channel in the top byte.
    for (genvar k = 0; k < c_NW; k++) begin : g_word
        for (genvar j = 0; j < 4; j++) begin : g_byte
            assign w_words[k][31-8*j -: 8] = w_src_data[8*(4*k+j) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ofm_in;
            r_fifo_addr[r_wr_ptr] <= w_base;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pix       <= '0;
            r_tile      <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_k         <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_ovf     <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            wr_en <= w_emit;
            done  <= 1'b0;
            if (w_emit) begin
                wr_addr <= w_src_addr + ADDR_W'(r_k);
                wr_data <= w_words[r_k];
                r_k     <= w_pop ? '0 : r_k + c_K_W'(1);
            end
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        busy        <= 1'b1;
                        r_pix       <= '0;
                        r_tile      <= '0;
                        err_ovf     <= 1'b0;
                        err_partial <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_partial) err_partial <= 1'b1;
                    if (w_ovf)     err_ovf     <= 1'b1;
                    // Dropped beats still advance the position so later
                    // addresses stay aligned to the pixel stream.
                    if (w_beat) begin
                        if (r_pix == c_PIX_LAST) begin
                            r_pix  <= '0;
                            r_tile <= (r_tile == c_TILE_LAST) ? '0 : r_tile + c_TILE_W'(1);
                        end else begin
                            r_pix <= r_pix + c_PIX_W'(1);
                        end
                    end
                    if (w_last_beat) r_state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (r_count == 2'd0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ofm_writeback.sv
//==============================================================================
// Module      : tb_ofm_writeback
// Description : Directed self-checking bench for ofm_writeback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ofm_writeback;

    localparam int NUM_PE = 16;
    localparam int ADDR_W = 20;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [NUM_PE-1:0]   valid;
    logic [NUM_PE*8-1:0] ofm_in;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [31:0]         wr_data;
    logic                busy;
    logic                done;
    logic                err_ovf;
    logic                err_partial;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [ADDR_W-1:0] q_addr [$];
    logic [31:0]       q_data [$];

    ofm_writeback #(
        .NUM_PE   (NUM_PE),
        .ADDR_W   (ADDR_W),
        .OFM_W    (56),
        .OFM_H    (56),
        .NUM_TILE (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valid       (valid),
        .ofm_in      (ofm_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .err_ovf     (err_ovf),
        .err_partial (err_partial)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    // Expected writes for one beat at (pix, tile) with 32 channels per pixel.
    task automatic expect_beat(input logic [NUM_PE*8-1:0] d, input int pix, input int tile);
        for (int k = 0; k < NUM_PE/4; k++)
            expect_word(ADDR_W'((pix*32 + tile*16)/4 + k),
                        {d[8*(4*k)+:8], d[8*(4*k+1)+:8], d[8*(4*k+2)+:8], d[8*(4*k+3)+:8]});
    endtask

    task automatic beat(input logic [NUM_PE*8-1:0] d);
        valid  = '1;
        ofm_in = d;
        tick();
        valid  = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        repeat (8) tick();
        check(tag, 64'(q_addr.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"},   64'(wr_en),       64'd0);
        check({tag, "_busy"},    64'(busy),        64'd0);
        check({tag, "_done"},    64'(done),        64'd0);
        check({tag, "_ovf"},     64'(err_ovf),     64'd0);
        check({tag, "_partial"}, 64'(err_partial), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (q_addr.size() == 0) begin
                    check("spurious_wr", 64'(wr_en), 64'd0);
                end else begin
                    check("wr_addr", 64'(wr_addr), 64'(q_addr[0]));
                    check("wr_data", 64'(wr_data), 64'(q_data[0]));
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                    last_addr <= wr_addr;
                end
            end
            if (done) n_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_PE*8-1:0] d;
        reset  = 1'b1;
        start  = 1'b0;
        valid  = '0;
        ofm_in = '0;

        // Power-on reset
        repeat (3) tick();
        check_idle_outputs("por");
        reset = 1'b0;
        tick();

        // Valid before start is ignored
        valid  = '1;
        ofm_in = {16{8'h5A}};
        repeat (3) tick();
        valid = '0;
        check("idle_busy", 64'(busy), 64'd0);
        wait_drain("idle_no_write");

        // Single beat: channels 0..15 carry 0x00..0x0F
        pulse_start();
        check("start_busy", 64'(busy), 64'd1);
        beat(128'h0F0E0D0C_0B0A0908_07060504_03020100);
        expect_word(20'd0, 32'h00010203);
        expect_word(20'd1, 32'h04050607);
        expect_word(20'd2, 32'h08090A0B);
        expect_word(20'd3, 32'h0C0D0E0F);
        wait_drain("single_beat");

        // Start during RUN must not restart counters: next beat is pixel 1
        pulse_start();
        d = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        expect_word(20'd8,  32'h00112233);
        expect_word(20'd9,  32'h44556677);
        expect_word(20'd10, 32'h8899AABB);
        expect_word(20'd11, 32'hCCDDEEFF);
        beat(d);
        wait_drain("restart_ignored");

        // Partial valid mid-layer: dropped, sticky error, pixel unchanged
        valid  = 16'h00FF;
        ofm_in = {16{8'h77}};
        tick();
        valid = '0;
        check("partial_flag", 64'(err_partial), 64'd1);
        d = {16{8'h3C}};
        expect_beat(d, 2, 0);
        beat(d);
        wait_drain("after_partial");

        // Reset mid-stream aborts the in-flight beat
        beat({16{8'hE1}});
        reset = 1'b1;
        repeat (3) tick();
        check_idle_outputs("midreset");
        reset = 1'b0;
        tick();
        wait_drain("abort_no_write");
        pulse_start();
        d = {16{8'h42}};
        expect_beat(d, 0, 0);
        beat(d);
        wait_drain("post_reset_addr0");

        // Back-to-back beats: third overflows, pixel still advances
        do_reset();
        pulse_start();
        expect_word(20'd0, 32'h10111213);
        expect_word(20'd1, 32'h14151617);
        expect_word(20'd2, 32'h18191A1B);
        expect_word(20'd3, 32'h1C1D1E1F);
        expect_word(20'd8, 32'h20212223);
        expect_word(20'd9, 32'h24252627);
        expect_word(20'd10, 32'h28292A2B);
        expect_word(20'd11, 32'h2C2D2E2F);
        valid  = '1;
        ofm_in = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
        tick();
        ofm_in = 128'h2F2E2D2C_2B2A2928_27262524_23222120;
        tick();
        ofm_in = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
        tick();
        valid = '0;
        check("ovf_flag", 64'(err_ovf), 64'd1);
        wait_drain("b2b_drain");
        expect_word(20'd24, 32'h40414243);
        expect_word(20'd25, 32'h44454647);
        expect_word(20'd26, 32'h48494A4B);
        expect_word(20'd27, 32'h4C4D4E4F);
        beat(128'h4F4E4D4C_4B4A4948_47464544_43424140);
        wait_drain("after_ovf_pix3");
        check("ovf_sticky", 64'(err_ovf), 64'd1);

        // Partial valid from a fresh layer; next full beat lands at addr 0
        do_reset();
        pulse_start();
        valid  = 16'h00FF;
        ofm_in = {16{8'h99}};
        tick();
        valid = '0;
        check("partial_fresh", 64'(err_partial), 64'd1);
        check("partial_no_ovf", 64'(err_ovf), 64'd0);
        wait_drain("partial_no_write");
        d = {16{8'hC3}};
        expect_beat(d, 0, 0);
        beat(d);
        wait_drain("partial_then_addr0");

        // Full layer: 2 tiles x 3136 pixels
        do_reset();
        n_done = 0;
        pulse_start();
        for (int b = 0; b < 6272; b++) begin
            for (int p = 0; p < NUM_PE; p++) d[8*p +: 8] = 8'(b*7 + p);
            expect_beat(d, b % 3136, b / 3136);
            beat(d);
            repeat (3) tick();
        end
        for (int t = 0; t < 50 && busy; t++) tick();
        tick();
        check("layer_busy_end", 64'(busy), 64'd0);
        check("layer_done_cnt", 64'(n_done), 64'd1);
        check("layer_last_addr", 64'(last_addr), 64'd25087);
        check("layer_ovf", 64'(err_ovf), 64'd0);
        check("layer_partial", 64'(err_partial), 64'd0);
        check("layer_queue", 64'(q_addr.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
